fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter AW, default 11, program address width; matches pc width.
REQ-002 Parameter IW, default 12, instruction width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum number of cycles a fetch may wait for acknowledge; legal range 1..255.
REQ-004 clk4  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 run  input  1  1 = fetch/execute sequencing enabled.
REQ-007 stall  input  1  1 = hold the current instruction in execute.
REQ-008 pc  input  AW  current program counter from the PC datapath.
REQ-009 mem_req  output  1  program memory read request.
REQ-010 mem_addr  output  AW  program memory read address.
REQ-011 mem_ack  input  1  program memory acknowledge; mem_data is valid in the same cycle.
REQ-012 mem_data  input  IW  program memory read data.
REQ-013 inst  output  IW  instruction register; feeds the PC datapath and decode.
REQ-014 inst_valid  output  1  inst holds an instruction in execute.
REQ-015 pc_step  output  1  one-cycle strobe; the PC datapath advances on this strobe.
REQ-016 fetch_err  output  1  sticky fetch-timeout flag.
REQ-017 retired  output  16  count of instructions completed.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, FETCH, EXEC and ERR.
REQ-019 IDLE: go to FETCH when run=1; otherwise stay in IDLE.
REQ-020 FETCH: mem_req=1 and mem_addr=pc, held stable on every FETCH cycle; the ack is sampled at the clock edge.
REQ-021 FETCH with mem_ack=1: capture mem_data into inst and go to EXEC; mem_req is 0 in the next cycle.
REQ-022 EXEC: inst_valid=1 and mem_req=0.
REQ-023 EXEC with stall=1: stay in EXEC with inst held and pc_step=0.
REQ-024 EXEC with stall=0: pc_step=1 (combinational, this cycle only), retired increments by 1, and the FSM goes to FETCH if run=1, else IDLE.
REQ-025 Minimum throughput is two cycles per instruction (one FETCH cycle, one EXEC cycle).
REQ-026 mem_ack outside FETCH SHALL be ignored, with no state or data change.
REQ-027 Timeout counter: cleared on entry to FETCH and incremented each FETCH cycle without ack.
REQ-028 Timeout: when the counter reaches TIMEOUT_CYCLES with no ack, go to ERR.
REQ-029 ERR: fetch_err=1, mem_req=0, inst_valid=0 and pc_step=0; stay in ERR until reset.
REQ-030 run deasserted during FETCH SHALL NOT abort the outstanding request; the instruction completes and the FSM then returns to IDLE.
REQ-031 retired SHALL wrap from 16'hFFFF to 16'h0000.
REQ-032 pc_step SHALL never be 1 for two consecutive cycles.

Reset
REQ-033 reset=1 at a rising edge SHALL override all other inputs, including reset in the middle of a fetch or a stall.
REQ-034 On reset the FSM SHALL go to IDLE.
REQ-035 On reset the outputs SHALL be: mem_req=0, mem_addr=0, inst=0, inst_valid=0, pc_step=0, fetch_err=0, retired=0.
REQ-036 On reset the timeout counter SHALL clear to 0.
REQ-037 An outstanding request at reset SHALL be abandoned, and a late mem_ack after reset SHALL be ignored (REQ-026).

Structure
REQ-038 Shared package fetch_pkg SHALL hold the state encoding and the default values of AW, IW and TIMEOUT_CYCLES.
REQ-039 The timeout counter SHALL be the single sub-module fetch_watchdog, with inputs clear and count and output expired.
REQ-040 All other logic SHALL reside in fetch_ctrl.

Verification
REQ-041 Reset release, run=1, mem_ack high on the first FETCH cycle with data 12'hA05 -> inst=12'hA05 and inst_valid=1 one cycle later; pc_step pulses once; retired=1.
REQ-042 Ack delayed 5 cycles -> mem_req high for exactly 6 cycles with mem_addr constant; inst captured on the ack cycle.
REQ-043 stall=1 for 3 EXEC cycles -> inst_valid=1 and pc_step=0 for those 3 cycles; pc_step pulses on the 4th cycle.
REQ-044 TIMEOUT_CYCLES=4 and no ack -> ERR after 4 FETCH cycles; fetch_err stays 1 and mem_req stays 0 until reset.
REQ-045 reset asserted during FETCH, then a late mem_ack -> FSM is in IDLE and all outputs equal their reset values; no capture occurs.
REQ-046 retired preloaded by 65535 retirements, then one more -> retired=16'h0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch/execute sequencer.
// Holds the FSM state encoding and the default sizing parameters.
package fetch_pkg;

   // Default program address width (matches the PC width).
   localparam int unsigned DEF_AW      = 11;
   // Default instruction width.
   localparam int unsigned DEF_IW      = 12;
   // Default fetch timeout in cycles (legal range 1..255).
   localparam int unsigned DEF_TIMEOUT = 255;
   // Watchdog counter width; wide enough for the largest timeout.
   localparam int unsigned WD_W        = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts FETCH cycles that wait for acknowledge.
// Ports: clk4/reset, clear (restart), count (one waiting cycle),
// expired (this waiting cycle is the last one allowed).
module fetch_watchdog
   import fetch_pkg::*;
#(
   parameter int unsigned LIMIT = DEF_TIMEOUT
) (
   input  logic clk4,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam logic [WD_W-1:0] LAST = WD_W'(LIMIT - 1);

   logic [WD_W-1:0] cnt;

   always_ff @(posedge clk4) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The counter would reach LIMIT at this edge: the fetch has run out.
   assign expired = count && (cnt == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IDLE/FETCH/EXEC/ERR sequencer for program fetch.
// Ports: clk4, reset, run, stall, pc in; mem_req/mem_addr out,
// mem_ack/mem_data in; inst, inst_valid, pc_step, fetch_err,
// retired (16-bit completed-instruction count) out.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned AW             = DEF_AW,
   parameter int unsigned IW             = DEF_IW,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic          clk4,
   input  logic          reset,
   input  logic          run,
   input  logic          stall,
   input  logic [AW-1:0] pc,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [IW-1:0] mem_data,
   output logic [IW-1:0] inst,
   output logic          inst_valid,
   output logic          pc_step,
   output logic          fetch_err,
   output logic [15:0]   retired
);

   fetch_state_e state;
   fetch_state_e state_nxt;

   logic wd_clear;
   logic wd_count;
   logic wd_expired;

   fetch_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wd (
      .clk4    (clk4),
      .reset   (reset),
      .clear   (wd_clear),
      .count   (wd_count),
      .expired (wd_expired)
   );

   always_ff @(posedge clk4) begin
      if (reset) begin
         state   <= ST_IDLE;
         inst    <= '0;
         retired <= '0;
      end else begin
         state <= state_nxt;
         // Acks outside FETCH never touch the instruction register.
         if (state == ST_FETCH && mem_ack) begin
            inst <= mem_data;
         end
         if (pc_step) begin
            retired <= retired + 16'd1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      mem_addr   = '0;
      inst_valid = 1'b0;
      pc_step    = 1'b0;
      fetch_err  = 1'b0;
      wd_count   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (run) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            wd_count = !mem_ack;
            // An ack on the last allowed cycle still wins.
            if (mem_ack) begin
               state_nxt = ST_EXEC;
            end else if (wd_expired) begin
               state_nxt = ST_ERR;
            end
         end
         ST_EXEC: begin
            inst_valid = 1'b1;
            if (!stall) begin
               pc_step   = 1'b1;
               state_nxt = run ? ST_FETCH : ST_IDLE;
            end
         end
         ST_ERR: begin
            fetch_err = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      // Reset dominates: nothing leaves the block during a reset cycle.
      if (reset) begin
         state_nxt  = ST_IDLE;
         mem_req    = 1'b0;
         mem_addr   = '0;
         inst_valid = 1'b0;
         pc_step    = 1'b0;
         fetch_err  = 1'b0;
         wd_count   = 1'b0;
      end
   end

   // Restart the timeout on every entry into FETCH.
   assign wd_clear = (state != ST_FETCH) && (state_nxt == ST_FETCH);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scenario bench for fetch_ctrl with an
// expected-instruction queue and a short-timeout second instance.
module tb_fetch_ctrl;

   localparam int AW = 11;
   localparam int IW = 12;

   logic clk4 = 1'b0;
   always #5 clk4 = ~clk4;

   logic          reset, run, stall, mem_ack;
   logic [AW-1:0] pc;
   logic [IW-1:0] mem_data;
   logic          mem_req, inst_valid, pc_step, fetch_err;
   logic [AW-1:0] mem_addr;
   logic [IW-1:0] inst;
   logic [15:0]   retired;

   logic          reset_t, run_t, stall_t, mem_ack_t;
   logic          mem_req_t, inst_valid_t, pc_step_t, fetch_err_t;
   logic [AW-1:0] mem_addr_t;
   logic [IW-1:0] inst_t;
   logic [15:0]   retired_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [IW-1:0] exp_q[$];
   logic [15:0]   m_ret;
   logic [IW-1:0] m_inst;

   fetch_ctrl #(.AW(AW), .IW(IW), .TIMEOUT_CYCLES(255)) dut (
      .clk4(clk4), .reset(reset), .run(run), .stall(stall), .pc(pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_data(mem_data), .inst(inst), .inst_valid(inst_valid),
      .pc_step(pc_step), .fetch_err(fetch_err), .retired(retired)
   );

   fetch_ctrl #(.AW(AW), .IW(IW), .TIMEOUT_CYCLES(4)) dut_to (
      .clk4(clk4), .reset(reset_t), .run(run_t), .stall(stall_t), .pc(pc),
      .mem_req(mem_req_t), .mem_addr(mem_addr_t), .mem_ack(mem_ack_t),
      .mem_data(mem_data), .inst(inst_t), .inst_valid(inst_valid_t),
      .pc_step(pc_step_t), .fetch_err(fetch_err_t), .retired(retired_t)
   );

   task automatic start();
      @(negedge clk4);
      run = 1'b1;
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; reset_t = 1'b1; run = 1'b0; run_t = 1'b0;
      stall = 1'b0; stall_t = 1'b0; mem_ack = 1'b0; mem_ack_t = 1'b0;
      mem_data = '0; pc = 11'h2C5;
      m_ret = '0; m_inst = '0;
      repeat (2) @(negedge clk4);
      reset = 1'b0; reset_t = 1'b0;
      #1;
      n_cmp++;
      if ({mem_req, inst_valid, pc_step, fetch_err} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_flags got %b want 0000",
                  {mem_req, inst_valid, pc_step, fetch_err});
      end
      n_cmp++;
      if (mem_addr !== '0 || inst !== '0) begin
         n_bad++;
         $display("FAIL reset_addr_inst got %h/%h want 0/0", mem_addr, inst);
      end
      n_cmp++;
      if (retired !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_retired got %h want 0000", retired);
      end
   endtask

   // One instruction: ack after 'delay' waiting cycles, then 'stalls'
   // stalled EXEC cycles (with stray acks), then retirement.
   task automatic test_fetch(input logic [IW-1:0] d, input int delay,
                             input int stalls, input bit run_after,
                             input bit drop_run);
      for (int i = 0; i <= delay; i++) begin
         @(negedge clk4);
         mem_ack = (i == delay);
         mem_data = (i == delay) ? d : ~d;
         run = drop_run ? 1'b0 : 1'b1;
         if (i == delay) begin
            exp_q.push_back(d);
            m_inst = d;
         end
         #1;
         n_cmp++;
         if ({mem_req, mem_addr, inst_valid, pc_step} !== {1'b1, pc, 2'b00}) begin
            n_bad++;
            $display("FAIL fetch_cyc%0d got req=%b addr=%h v=%b s=%b want 1/%h/0/0",
                     i, mem_req, mem_addr, inst_valid, pc_step, pc);
         end
      end
      for (int s = 0; s <= stalls; s++) begin
         @(negedge clk4);
         stall = (s < stalls);
         mem_ack = (s < stalls);
         mem_data = d ^ 12'hFFF;
         run = run_after;
         #1;
         n_cmp++;
         if ({inst_valid, mem_req, pc_step} !== {1'b1, 1'b0, s == stalls}) begin
            n_bad++;
            $display("FAIL exec_cyc%0d got v=%b req=%b step=%b want 1/0/%b",
                     s, inst_valid, mem_req, pc_step, s == stalls);
         end
         n_cmp++;
         if (exp_q.size() == 0 || inst !== exp_q[0]) begin
            n_bad++;
            $display("FAIL exec_inst%0d got %h want %h", s, inst, d);
         end
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      m_ret = m_ret + 16'd1;
      @(posedge clk4);
      #1;
      n_cmp++;
      if (retired !== m_ret) begin
         n_bad++;
         $display("FAIL retired got %h want %h", retired, m_ret);
      end
      n_cmp++;
      if ({pc_step, inst_valid, mem_req} !== {2'b00, run_after}) begin
         n_bad++;
         $display("FAIL after_exec got %b want 00%b",
                  {pc_step, inst_valid, mem_req}, run_after);
      end
   endtask

   task automatic test_basic();
      start();
      test_fetch(12'hA05, 0, 0, 1'b0, 1'b0);
      n_cmp++;
      if (retired !== 16'd1 || inst !== 12'hA05) begin
         n_bad++;
         $display("FAIL basic got ret=%h inst=%h want 0001/a05", retired, inst);
      end
   endtask

   task automatic test_delay();
      start();
      test_fetch(12'h3B7, 5, 0, 1'b0, 1'b0);
   endtask

   task automatic test_stall();
      start();
      test_fetch(12'h5C1, 0, 3, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      start();
      test_fetch(12'h111, 0, 0, 1'b1, 1'b0);
      test_fetch(12'h222, 0, 0, 1'b1, 1'b0);
      test_fetch(12'h333, 2, 1, 1'b0, 1'b0);
   endtask

   task automatic test_run_drop();
      start();
      test_fetch(12'h6E6, 2, 0, 1'b0, 1'b1);
   endtask

   task automatic test_idle_ack();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk4);
         run = 1'b0;
         mem_ack = 1'b1;
         mem_data = 12'h3C3;
         #1;
         n_cmp++;
         if (inst !== m_inst || {mem_req, inst_valid, pc_step} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_ack%0d got inst=%h flags=%b want %h/000",
                     i, inst, {mem_req, inst_valid, pc_step}, m_inst);
         end
      end
      @(negedge clk4);
      mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (inst !== m_inst || retired !== m_ret) begin
         n_bad++;
         $display("FAIL idle_hold got %h/%h want %h/%h", inst, retired, m_inst, m_ret);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk4);
      run = 1'b0;
      force dut.retired = 16'hFFFF;
      #1;
      release dut.retired;
      m_ret = 16'hFFFF;
      #1;
      n_cmp++;
      if (retired !== m_ret) begin
         n_bad++;
         $display("FAIL wrap_preload got %h want ffff", retired);
      end
      start();
      test_fetch(12'h0E1, 1, 0, 1'b0, 1'b0);
      n_cmp++;
      if (retired !== 16'h0000) begin
         n_bad++;
         $display("FAIL wrap got %h want 0000", retired);
      end
   endtask

   task automatic test_reset_fetch();
      start();
      @(negedge clk4);
      mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_fetch_req got %b want 1", mem_req);
      end
      @(negedge clk4);
      reset = 1'b1; run = 1'b1; stall = 1'b1;
      mem_ack = 1'b1; mem_data = 12'h5A5;
      @(negedge clk4);
      reset = 1'b0; run = 1'b0; stall = 1'b0;
      mem_ack = 1'b1;
      m_ret = '0; m_inst = '0;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if ({mem_req, inst_valid, pc_step, fetch_err} !== 4'b0000 ||
             mem_addr !== '0 || inst !== '0 || retired !== '0) begin
            n_bad++;
            $display("FAIL rst_late_ack%0d got f=%b a=%h i=%h r=%h want 0000/0/0/0",
                     i, {mem_req, inst_valid, pc_step, fetch_err},
                     mem_addr, inst, retired);
         end
         @(negedge clk4);
         mem_ack = 1'b0;
      end
   endtask

   task automatic test_timeout();
      @(negedge clk4);
      run_t = 1'b1;
      mem_ack_t = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk4);
         mem_ack_t = (i == 3);
         mem_data = 12'h4D2;
         #1;
         n_cmp++;
         if ({mem_req_t, mem_addr_t, fetch_err_t} !== {1'b1, pc, 1'b0}) begin
            n_bad++;
            $display("FAIL to_edge_cyc%0d got req=%b addr=%h err=%b want 1/%h/0",
                     i, mem_req_t, mem_addr_t, fetch_err_t, pc);
         end
      end
      @(negedge clk4);
      run_t = 1'b0;
      mem_ack_t = 1'b0;
      #1;
      n_cmp++;
      if ({inst_valid_t, pc_step_t, fetch_err_t} !== 3'b110 || inst_t !== 12'h4D2) begin
         n_bad++;
         $display("FAIL to_edge_exec got %b inst=%h want 110/4d2",
                  {inst_valid_t, pc_step_t, fetch_err_t}, inst_t);
      end
      @(negedge clk4);
      run_t = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk4);
         mem_ack_t = 1'b0;
         #1;
         n_cmp++;
         if ({mem_req_t, fetch_err_t} !== 2'b10) begin
            n_bad++;
            $display("FAIL to_wait_cyc%0d got %b want 10", i, {mem_req_t, fetch_err_t});
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk4);
         mem_ack_t = (i > 0);
         mem_data = 12'h999;
         #1;
         n_cmp++;
         if ({fetch_err_t, mem_req_t, inst_valid_t, pc_step_t} !== 4'b1000 ||
             inst_t !== 12'h4D2) begin
            n_bad++;
            $display("FAIL to_err%0d got %b inst=%h want 1000/4d2",
                     i, {fetch_err_t, mem_req_t, inst_valid_t, pc_step_t}, inst_t);
         end
      end
      @(negedge clk4);
      reset_t = 1'b1;
      @(negedge clk4);
      reset_t = 1'b0;
      run_t = 1'b0;
      mem_ack_t = 1'b0;
      #1;
      n_cmp++;
      if (fetch_err_t !== 1'b0 || retired_t !== 16'h0000 || inst_t !== '0) begin
         n_bad++;
         $display("FAIL to_reset got err=%b ret=%h inst=%h want 0/0000/000",
                  fetch_err_t, retired_t, inst_t);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_delay();
      test_back_to_back();
      test_run_drop();
      test_idle_ack();
      test_wrap();
      test_reset_fetch();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
